instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/rv_core_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared fetch-stage types: FSM state, buffered fetch entry, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_core_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,   // issuing sequential fetches
        S_HALT = 1'b1    // stopped after a fault or misaligned target
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        fault;
        logic        misaligned;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Width of the count of responses still to be discarded. Repeated
    // redirects with requests in flight add to it, so it is wider than
    // the outstanding counter.
    localparam int DROP_W = 8;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode, DEPTH entries (power of two).
// Latency: a push is visible at o_head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush wins over pop.
// Ports: clk, rst_n (async active-low); i_push/i_push_dat, i_pop, i_flush;
//        o_head (oldest entry), o_full, o_empty, o_count.
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_do_push;
    logic           w_do_pop;
    logic           w_wr_en;
    logic [AW-1:0]  w_wr_idx;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // A push in the flush cycle lands in a freshly emptied buffer at slot 0.
    assign w_wr_en   = i_flush ? i_push : w_do_push;
    assign w_wr_idx  = i_flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? AW'(1) : '0;
            r_count  <= i_push ? (AW+1)'(1) : '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage is not reset; o_empty gates everything that reads it.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_idx] <= i_push_dat;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-limited sequential fetch, in-order response buffering, redirect/fault handling.
// Latency: request the cycle after reset/redirect; entry visible to decode the cycle after its response.
// Backpressure: outstanding + buffered never exceeds FIFO_DEPTH, so if_ready low stalls requests, never drops.
// Ports: clk, rst_n; imem_req_* (valid/ready/addr), imem_rsp_* (valid/data/error);
//        redirect_valid/redirect_pc; if_* decode interface (valid/ready/instruction/pc/fault/misaligned).
// Option: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets instead of truncating them.
module instruction_fetch
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_error,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_fault,
    output logic        if_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       r_state;
    logic [31:0]        r_fetch_pc;
    logic [CW-1:0]      r_outstanding;
    logic [DROP_W-1:0]  r_drop_count;

    logic [31:0]        w_redirect_pc;
    logic               w_mis_redirect;
    logic               w_credit_ok;
    logic               w_accept;
    logic               w_rsp_drop;
    logic               w_rsp_live;
    logic               w_push_rsp;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_rsp_pc;
    fetch_entry_t       w_push_dat;
    fetch_entry_t       w_head;
    logic               w_fifo_empty;
    logic               w_fifo_full_unused;
    logic [CW-1:0]      w_fifo_count;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redirect_pc  = redirect_pc;
    assign w_mis_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_mis_redirect  = 1'b0;
`endif

    // Credits: every accepted request must have a guaranteed buffer slot.
    assign w_credit_ok    = ((CW+1)'(r_outstanding) + (CW+1)'(w_fifo_count)) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = rst_n && (r_state == S_RUN) && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Stale responses (from before a redirect) are consumed first; a response
    // with nothing tracked (e.g. issued before reset) is ignored.
    assign w_rsp_drop = imem_rsp_valid && (r_drop_count != '0);
    assign w_rsp_live = imem_rsp_valid && (r_drop_count == '0) && (r_outstanding != '0);
    assign w_push_rsp = w_rsp_live && (r_state == S_RUN) && !redirect_valid;

    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one sits outstanding words back; no per-request PC storage.
    assign w_rsp_pc = r_fetch_pc - 32'({r_outstanding, 2'b00});

    always_comb begin
        w_push_dat = '0;
        if (w_mis_redirect) begin
            w_push_dat = '{instruction: INSTR_NOP, pc: redirect_pc, fault: 1'b0, misaligned: 1'b1};
        end else if (imem_rsp_error) begin
            w_push_dat = '{instruction: INSTR_NOP, pc: w_rsp_pc, fault: 1'b1, misaligned: 1'b0};
        end else begin
            w_push_dat = '{instruction: imem_rsp_data, pc: w_rsp_pc, fault: 1'b0, misaligned: 1'b0};
        end
    end

    assign w_push = w_push_rsp || w_mis_redirect;
    assign if_valid = rst_n && !w_fifo_empty && !redirect_valid;
    assign w_pop = if_valid && if_ready;

    assign if_instruction = w_fifo_empty ? '0   : w_head.instruction;
    assign if_pc          = w_fifo_empty ? '0   : w_head.pc;
    assign if_fault       = w_fifo_empty ? 1'b0 : w_head.fault;
    assign if_misaligned  = w_fifo_empty ? 1'b0 : w_head.misaligned;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head     (w_head),
        .o_full     (w_fifo_full_unused),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_fetch_pc    <= RESET_VECTOR;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else if (redirect_valid) begin
            // Everything in flight, minus a response consumed this cycle, becomes stale.
            r_fetch_pc    <= w_redirect_pc;
            r_outstanding <= '0;
            r_drop_count  <= r_drop_count + DROP_W'(r_outstanding)
                             - DROP_W'(w_rsp_drop || w_rsp_live);
            r_state       <= w_mis_redirect ? S_HALT : S_RUN;
        end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_live);
            if (w_rsp_drop) r_drop_count <= r_drop_count - DROP_W'(1);
            if (w_push_rsp && imem_rsp_error) r_state <= S_HALT;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_error = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        if_misaligned;

    int total = 0;
    int bad = 0;

    // Memory model state
    int          lat = 1;
    int          n_neg = 0;
    int          n_accept = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_VECTOR(32'h0000_0000),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_error (imem_rsp_error),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_fault       (if_fault),
        .if_misaligned  (if_misaligned)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // In-order memory with fixed latency `lat`; works on the falling edge so
    // the request handshake seen here is the one the next rising edge takes.
    always @(negedge clk) begin
        n_neg = n_neg + 1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_error = 1'b0;
        if (q_addr.size() > 0 && q_due[0] <= n_neg) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(q_addr[0]);
            imem_rsp_error = err_en && (q_addr[0] == err_addr);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (rst_n && imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(n_neg + lat);
            n_accept = n_accept + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        err_en = 1'b0;
        lat = 1;
        q_addr.delete();
        q_due.delete();
        tick;
        tick;
        n_accept = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_entry(output logic ok, output logic [31:0] pc, output logic [31:0] ins,
                              output logic flt, output logic mis);
        ok = 1'b0; pc = 32'h0; ins = 32'h0; flt = 1'b0; mis = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (if_valid && if_ready) begin
                ok = 1'b1; pc = if_pc; ins = if_instruction; flt = if_fault; mis = if_misaligned;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b exp=0", imem_req_valid); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%0b exp=0", if_valid); end
        total++; if (if_fault !== 1'b0 || if_misaligned !== 1'b0) begin bad++; $display("FAIL rst_markers got=%0b%0b exp=00", if_fault, if_misaligned); end
        total++; if (if_pc !== 32'h0 || if_instruction !== 32'h0) begin bad++; $display("FAIL rst_if_data got pc=%h ins=%h exp=0/0", if_pc, if_instruction); end
        do_reset;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_req got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_c0_valid got=%0b exp=0", if_valid); end
        tick;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%0b exp=0", if_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL stream_c1_req got v=%0b a=%h exp v=1 a=4", imem_req_valid, imem_req_addr); end
        tick;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'hDEAD_0000) begin bad++; $display("FAIL stream_c2_entry got v=%0b pc=%h ins=%h exp v=1 pc=0 ins=dead0000", if_valid, if_pc, if_instruction); end
        for (int k = 0; k < 6; k++) begin
            wait_entry(ok, pc, ins, flt, mis);
            total++; if (!ok || pc !== 32'(4*k) || ins !== (32'(4*k) ^ 32'hDEAD_0000) || flt !== 1'b0) begin bad++; $display("FAIL stream_entry%0d got ok=%0b pc=%h ins=%h f=%0b exp pc=%h", k, ok, pc, ins, flt, 32'(4*k)); end
        end
    endtask

    task automatic test_stall;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        if_ready = 1'b0;
        imem_req_ready = 1'b0;
        tick; tick; tick;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL stall_hold got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        n_accept = 0;
        repeat (10) tick;
        total++; if (n_accept !== 2) begin bad++; $display("FAIL stall_accepts got=%0d exp=2", n_accept); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_low got=%0b exp=0", imem_req_valid); end
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_head got v=%0b pc=%h exp v=1 pc=0", if_valid, if_pc); end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_entry(ok, pc, ins, flt, mis);
            total++; if (!ok || pc !== 32'(4*k)) begin bad++; $display("FAIL stall_drain%0d got ok=%0b pc=%h exp %h", k, ok, pc, 32'(4*k)); end
        end
    endtask

    task automatic test_redirect;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        lat = 3;
        tick; tick;
        total++; if (n_accept !== 2) begin bad++; $display("FAIL redir_inflight got=%0d exp=2", n_accept); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        total++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle got req=%0b ifv=%0b exp 0/0", imem_req_valid, if_valid); end
        tick;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_req got v=%0b a=%h exp v=1 a=100", imem_req_valid, imem_req_addr); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h100 || ins !== 32'hDEAD_0100) begin bad++; $display("FAIL redir_first got ok=%0b pc=%h ins=%h exp pc=100 ins=dead0100", ok, pc, ins); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h104) begin bad++; $display("FAIL redir_second got ok=%0b pc=%h exp 104", ok, pc); end
    endtask

    task automatic test_back_to_back;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        lat = 3;
        tick; tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick;
        redirect_pc = 32'h400;
        tick;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin bad++; $display("FAIL b2b_req got v=%0b a=%h exp v=1 a=400", imem_req_valid, imem_req_addr); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h400 || ins !== 32'hDEAD_0400) begin bad++; $display("FAIL b2b_first got ok=%0b pc=%h ins=%h exp pc=400", ok, pc, ins); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h404) begin bad++; $display("FAIL b2b_second got ok=%0b pc=%h exp 404", ok, pc); end
    endtask

    task automatic test_fault;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        err_en = 1'b1;
        err_addr = 32'h8;
        for (int k = 0; k < 2; k++) begin
            wait_entry(ok, pc, ins, flt, mis);
            total++; if (!ok || pc !== 32'(4*k) || flt !== 1'b0) begin bad++; $display("FAIL fault_pre%0d got ok=%0b pc=%h f=%0b exp pc=%h f=0", k, ok, pc, flt, 32'(4*k)); end
        end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h8 || flt !== 1'b1 || ins !== 32'h0000_0013) begin bad++; $display("FAIL fault_entry got ok=%0b pc=%h f=%0b ins=%h exp pc=8 f=1 ins=13", ok, pc, flt, ins); end
        tick; tick;
        n_accept = 0;
        repeat (8) tick;
        total++; if (n_accept !== 0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL fault_halt got acc=%0d req=%0b exp 0/0", n_accept, imem_req_valid); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fault_no_stale got=%0b exp=0", if_valid); end
        err_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL fault_resume_req got v=%0b a=%h exp v=1 a=200", imem_req_valid, imem_req_addr); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h200 || flt !== 1'b0 || ins !== 32'hDEAD_0200) begin bad++; $display("FAIL fault_resume_entry got ok=%0b pc=%h f=%0b ins=%h exp pc=200", ok, pc, flt, ins); end
    endtask

    task automatic test_misalign;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        wait_entry(ok, pc, ins, flt, mis);
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick;
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL misal_no_req got=%0b exp=0", imem_req_valid); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h102 || mis !== 1'b1 || ins !== 32'h0000_0013) begin bad++; $display("FAIL misal_entry got ok=%0b pc=%h m=%0b ins=%h exp pc=102 m=1 ins=13", ok, pc, mis, ins); end
`else
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL misal_req got v=%0b a=%h exp v=1 a=100", imem_req_valid, imem_req_addr); end
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h100 || mis !== 1'b0 || ins !== 32'hDEAD_0100) begin bad++; $display("FAIL misal_entry got ok=%0b pc=%h m=%0b ins=%h exp pc=100 m=0", ok, pc, mis, ins); end
`endif
    endtask

    task automatic test_reset_mid;
        logic ok, flt, mis; logic [31:0] pc, ins;
        do_reset;
        if_ready = 1'b0;
        repeat (10) tick;
        total++; if (if_valid !== 1'b1 || if_instruction !== 32'hDEAD_0000) begin bad++; $display("FAIL midrst_pre got v=%0b ins=%h exp v=1 ins=dead0000", if_valid, if_instruction); end
        rst_n = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL midrst_valids got req=%0b ifv=%0b exp 0/0", imem_req_valid, if_valid); end
        total++; if (if_pc !== 32'h0 || if_instruction !== 32'h0 || if_fault !== 1'b0) begin bad++; $display("FAIL midrst_data got pc=%h ins=%h f=%0b exp 0", if_pc, if_instruction, if_fault); end
        q_addr.delete();
        q_due.delete();
        tick;
        rst_n = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL midrst_restart got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
        if_ready = 1'b1;
        wait_entry(ok, pc, ins, flt, mis);
        total++; if (!ok || pc !== 32'h0 || ins !== 32'hDEAD_0000) begin bad++; $display("FAIL midrst_entry got ok=%0b pc=%h ins=%h exp pc=0", ok, pc, ins); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_back_to_back;
        test_fault;
        test_misalign;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
